// File: rtl/attack_hitbox_resolver.sv
// ============================================================================
// attack_hitbox_resolver
//
// Runs one attacker's move timeline (STARTUP -> ACTIVE -> RECOVERY) paced by
// frame_tick. It tests the move's hitbox against the defender's hurtbox on
// every ACTIVE frame. On an overlap it emits a one-cycle got_hit pulse with
// damage and knockback direction for the defender's hit FSM. A move can land
// at most one hit.
//
// Optional feature (macro HIT_STALE_EN):
//   A 4-entry history of landed attack_ids scales down the damage of moves
//   that repeat. The default build (macro undefined) always reports the
//   table damage.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   frame_tick          one-cycle pulse per video frame
//   attack_start        request to begin a move (accepted only when idle)
//   attack_id[1:0]      0 jab, 1 tilt, 2 smash, 3 aerial
//   facing              1 = right, 0 = left (latched at move start)
//   attacker_x/y        attacker top-left position, sampled every frame
//   defender_x/y        defender hurtbox top-left, sampled every frame
//   defender_invincible defender cannot be hit
//   attack_cancel       attacker was hit; abort the move
//   got_hit             one-cycle hit pulse
//   hit_damage[5:0]     damage, valid while got_hit = 1
//   hit_dir             knockback direction (latched facing)
//   attack_busy         high whenever not IDLE
//   attack_phase[1:0]   0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY
// ============================================================================
module attack_hitbox_resolver #(
    parameter int HURT_W  = 16,
    parameter int HURT_H  = 24,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               attack_start,
    input  logic [1:0]         attack_id,
    input  logic               facing,
    input  logic [COORD_W-1:0] attacker_x,
    input  logic [COORD_W-1:0] attacker_y,
    input  logic [COORD_W-1:0] defender_x,
    input  logic [COORD_W-1:0] defender_y,
    input  logic               defender_invincible,
    input  logic               attack_cancel,
    output logic               got_hit,
    output logic [5:0]         hit_damage,
    output logic               hit_dir,
    output logic               attack_busy,
    output logic [1:0]         attack_phase
);

    // Two extra bits: one for headroom on the additions, one for the sign,
    // so a hitbox hanging off the left edge compares as negative.
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] HURT_W_S = SW'(HURT_W);
    localparam logic signed [SW-1:0] HURT_H_S = SW'(HURT_H);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STARTUP  = 2'd1,
        S_ACTIVE   = 2'd2,
        S_RECOVERY = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] su;
        logic [3:0] ac;
        logic [3:0] rc;
        logic [4:0] off_x;
        logic [4:0] off_y;
        logic [4:0] w;
        logic [4:0] h;
        logic [5:0] dmg;
    } move_t;

    // Fixed move table: frame counts, hitbox offset/size, base damage.
    function automatic move_t move_lookup(input logic [1:0] id);
        move_t m;
        case (id)
            2'd0:    m = '{su: 4'd2,  ac: 4'd2, rc: 4'd4,  off_x: 5'd12, off_y: 5'd4,
                           w: 5'd12, h: 5'd8,  dmg: 6'd3};
            2'd1:    m = '{su: 4'd4,  ac: 4'd3, rc: 4'd8,  off_x: 5'd14, off_y: 5'd0,
                           w: 5'd16, h: 5'd12, dmg: 6'd7};
            2'd2:    m = '{su: 4'd10, ac: 4'd3, rc: 4'd14, off_x: 5'd16, off_y: 5'd0,
                           w: 5'd20, h: 5'd16, dmg: 6'd15};
            default: m = '{su: 4'd3,  ac: 4'd6, rc: 4'd6,  off_x: 5'd0,  off_y: 5'd8,
                           w: 5'd20, h: 5'd12, dmg: 6'd9};
        endcase
        return m;
    endfunction

    function automatic logic [3:0] startup_frames(input logic [1:0] id);
        move_t m;
        m = move_lookup(id);
        return m.su;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] id_q, id_d;
    logic       facing_q, facing_d;
    logic       hit_latched_q, hit_latched_d;
    logic       got_hit_q, got_hit_d;
    logic [5:0] hit_damage_q, hit_damage_d;
    logic       hit_dir_q, hit_dir_d;

    move_t      cur_mv;
    logic [5:0] eff_dmg;
    logic       overlap;

    logic signed [SW-1:0] ax_s, ay_s, dx_s, dy_s;
    logic signed [SW-1:0] off_x_s, off_y_s, w_s, h_s;
    logic signed [SW-1:0] hx, hy;

    assign cur_mv = move_lookup(id_q);

    // Hitbox placement: a left-facing move mirrors around the attacker's
    // left edge, so the box ends off_x pixels before ax.
    always_comb begin
        ax_s    = $signed({2'b00, attacker_x});
        ay_s    = $signed({2'b00, attacker_y});
        dx_s    = $signed({2'b00, defender_x});
        dy_s    = $signed({2'b00, defender_y});
        off_x_s = $signed({{(SW-5){1'b0}}, cur_mv.off_x});
        off_y_s = $signed({{(SW-5){1'b0}}, cur_mv.off_y});
        w_s     = $signed({{(SW-5){1'b0}}, cur_mv.w});
        h_s     = $signed({{(SW-5){1'b0}}, cur_mv.h});
        hx      = facing_q ? (ax_s + off_x_s) : (ax_s - off_x_s - w_s);
        hy      = ay_s + off_y_s;
        overlap = (hx < dx_s + HURT_W_S) && (dx_s < hx + w_s) &&
                  (hy < dy_s + HURT_H_S) && (dy_s < hy + h_s);
    end

`ifdef HIT_STALE_EN
    logic [3:0][1:0] fifo_q, fifo_d;
    logic [2:0]      fifo_cnt_q, fifo_cnt_d;
    logic [2:0]      stale_n;
    logic [5:0]      stale_dmg;

    // Count how often the current move already landed recently and shave
    // n/8 of the base damage off, never going below 1.
    always_comb begin
        stale_n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < fifo_cnt_q) && (fifo_q[i] == id_q)) begin
                stale_n = stale_n + 3'd1;
            end
        end
        stale_dmg = cur_mv.dmg - 6'(({3'b000, cur_mv.dmg} * {6'b000000, stale_n}) >> 3);
        if (stale_dmg == 6'd0) begin
            stale_dmg = 6'd1;
        end
        eff_dmg = stale_dmg;
    end
`else
    assign eff_dmg = cur_mv.dmg;
`endif

    // Next-state logic. Cancel outranks everything while a move runs; hit
    // evaluation happens on an ACTIVE frame_tick, including the one that
    // moves the timeline into RECOVERY.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        id_d          = id_q;
        facing_d      = facing_q;
        hit_latched_d = hit_latched_q;
        got_hit_d     = 1'b0;
        hit_damage_d  = hit_damage_q;
        hit_dir_d     = hit_dir_q;
`ifdef HIT_STALE_EN
        fifo_d        = fifo_q;
        fifo_cnt_d    = fifo_cnt_q;
`endif
        if (state_q == S_IDLE) begin
            hit_latched_d = 1'b0;
            if (attack_start) begin
                id_d     = attack_id;
                facing_d = facing;
                cnt_d    = startup_frames(attack_id);
                state_d  = S_STARTUP;
            end
        end else if (attack_cancel) begin
            state_d       = S_IDLE;
            cnt_d         = 4'd0;
            hit_latched_d = 1'b0;
        end else if (frame_tick) begin
            if ((state_q == S_ACTIVE) && overlap && !defender_invincible && !hit_latched_q) begin
                got_hit_d     = 1'b1;
                hit_damage_d  = eff_dmg;
                hit_dir_d     = facing_q;
                hit_latched_d = 1'b1;
`ifdef HIT_STALE_EN
                if (fifo_cnt_q < 3'd4) begin
                    fifo_d[fifo_cnt_q[1:0]] = id_q;
                    fifo_cnt_d              = fifo_cnt_q + 3'd1;
                end else begin
                    fifo_d = {id_q, fifo_q[3:1]};
                end
`endif
            end
            if (cnt_q == 4'd1) begin
                case (state_q)
                    S_STARTUP: begin
                        state_d = S_ACTIVE;
                        cnt_d   = cur_mv.ac;
                    end
                    S_ACTIVE: begin
                        state_d = S_RECOVERY;
                        cnt_d   = cur_mv.rc;
                    end
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                endcase
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            id_q          <= 2'd0;
            facing_q      <= 1'b0;
            hit_latched_q <= 1'b0;
            got_hit_q     <= 1'b0;
            hit_damage_q  <= 6'd0;
            hit_dir_q     <= 1'b0;
`ifdef HIT_STALE_EN
            fifo_q        <= '0;
            fifo_cnt_q    <= 3'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            id_q          <= id_d;
            facing_q      <= facing_d;
            hit_latched_q <= hit_latched_d;
            got_hit_q     <= got_hit_d;
            hit_damage_q  <= hit_damage_d;
            hit_dir_q     <= hit_dir_d;
`ifdef HIT_STALE_EN
            fifo_q        <= fifo_d;
            fifo_cnt_q    <= fifo_cnt_d;
`endif
        end
    end

    assign got_hit      = got_hit_q;
    assign hit_damage   = hit_damage_q;
    assign hit_dir      = hit_dir_q;
    assign attack_busy  = (state_q != S_IDLE);
    assign attack_phase = state_q;

endmodule

// File: doc/attack_hitbox_resolver.md
Name: attack_hitbox_resolver

Overview:
- Upstream neighbour of the per-player hit FSM: runs the attacker's move timeline (startup/active/recovery) and tests the move's hitbox against the defender's hurtbox once per frame.
- On overlap, emits the one-cycle got_hit pulse and 6-bit damage the hit FSM consumes.
- One instance per attacker→defender pair, clocked on the system clock, paced by frame_tick.

Parameters:
- HURT_W, 16, defender hurtbox width in pixels
- HURT_H, 24, defender hurtbox height in pixels
- COORD_W, 10, width of position coordinates

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- attack_start  in  1  request to begin a move
- attack_id  in  2  move select: 0 jab, 1 tilt, 2 smash, 3 aerial
- facing  in  1  attacker facing; 1 = right, 0 = left
- attacker_x, attacker_y  in  COORD_W  attacker top-left position
- defender_x, defender_y  in  COORD_W  defender hurtbox top-left
- defender_invincible  in  1  defender cannot be hit
- attack_cancel  in  1  attacker was hit; abort the move
- got_hit  out  1  one-cycle hit pulse to the defender's hit FSM
- hit_damage  out  6  damage for this hit; valid while got_hit = 1
- hit_dir  out  1  knockback direction; equals latched facing
- attack_busy  out  1  high in any state other than IDLE
- attack_phase  out  2  0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; counters and latches cleared. Reset mid-move returns to IDLE with no pending hit.
- Fixed move table (startup/active/recovery frames; off_x, off_y, w, h; damage):
  - jab 2/2/4; 12,4,12,8; 3
  - tilt 4/3/8; 14,0,16,12; 7
  - smash 10/3/14; 16,0,20,16; 15
  - aerial 3/6/6; 0,8,20,12; 9
- Move start:
  - attack_start is accepted only in IDLE; ignored while busy.
  - On acceptance, latch attack_id and facing, then enter STARTUP on the next clk.
  - Positions are not latched; they are re-sampled every frame.
- Phase timing:
  - Each phase lasts exactly its table count of frame_ticks.
  - The phase counter loads on entry and decrements on frame_tick.
  - On the frame_tick where the counter equals 1, advance: STARTUP→ACTIVE→RECOVERY→IDLE.
- Hitbox geometry (COORD_W+2-bit signed arithmetic, no clamping):
  - Right-facing: hx = ax + off_x.
  - Left-facing: hx = ax − off_x − w.
  - hy = ay + off_y.
- Overlap test:
  - overlap = (hx < dx+HURT_W) && (dx < hx+w) && (hy < dy+HURT_H) && (dy < hy+h).
  - Strict compares, so edge-touching is not a hit.
  - A negative hx is legal and simply fails the compare where appropriate.
- Evaluation:
  - Runs on every frame_tick while in ACTIVE, including the last active frame.
  - Positions are sampled in the frame_tick cycle.
  - If overlap && !defender_invincible && !hit_latched: got_hit = 1 exactly one clk later, with hit_damage and hit_dir valid in the same cycle; then set hit_latched.
- Single hit per move: hit_latched blocks any further hit until the move returns to IDLE, where hit_latched clears.
- attack_cancel:
  - In any non-IDLE state, forces IDLE on the next clk and suppresses any got_hit pending from the same frame_tick.
  - Cancel wins over hit evaluation and over a simultaneous attack_start.
- attack_start coinciding with the RECOVERY→IDLE frame_tick is ignored; it must be re-requested once in IDLE.
- got_hit is never asserted outside the cycle after an ACTIVE-phase frame_tick.

Optional Feature:
- Macro: HIT_STALE_EN.
- Defined:
  - A 4-entry FIFO records the attack_id of each landed hit; it is cleared by reset.
  - Damage = table_damage − (table_damage × n) >> 3, where n (0..4) is the count of FIFO entries matching the current attack_id, computed before the push.
  - Minimum damage is 1. The push occurs in the got_hit cycle; the oldest entry drops when full.
- Undefined: no FIFO; hit_damage is always the table value.

Test Plan:
- Jab, facing right, attacker (100,100), defender (115,100) → hitbox x 112..124 overlaps; single got_hit with damage 3 one clk after ACTIVE frame_tick #1; none on frame #2; busy for exactly 8 frames.
- Same jab, facing left, defender (115,100) → no got_hit; defender (70,100) → hit (hitbox x 76..88).
- Smash with defender_invincible high during ACTIVE → got_hit never asserts; attack_phase sequence 1(10 frames), 2(3), 3(14), 0.
- attack_cancel during STARTUP of tilt → attack_phase 0 next clk; a new attack_start is then accepted; attack_start while busy is ignored.
- Edge touch: defender_x = hx + w exactly → no hit; defender_x = hx + w − 1 → hit.
- HIT_STALE_EN: land tilt 3 times → damages 7, 7 − (7×1>>3) = 7, 7 − (7×2>>3) = 6; reset clears the history.
